adder_slice_sequencer: RTL and testbench



---
 rtl/adder_seq_pkg.sv | 19 +
 rtl/adder_slice_sequencer_if.sv | 27 ++
 rtl/adder_slice.sv | 12 +
 rtl/adder_slice_sequencer.sv | 146 ++++++++++++++
 tb/tb_adder_slice_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/adder_seq_pkg.sv
// Shared FSM encoding and sizing helpers for the slice-serial adder sequencer.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned ns_f(input int unsigned n, input int unsigned w);
        return n / w;
    endfunction

    // Slice index width; a floor of 1 keeps the index a legal vector.
    function automatic int unsigned idx_w_f(input int unsigned ns);
        return (ns < 2) ? 1 : $clog2(ns);
    endfunction

endpackage

// File: rtl/adder_slice_sequencer_if.sv
// Operand/result handshake bundle for adder_slice_sequencer.
interface adder_slice_sequencer_if #(
    parameter int unsigned N = 256
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         cout;
    logic         busy;
    logic         prop;
    logic         gen;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, s, cout, busy, prop, gen
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, s, cout, busy, prop, gen
    );
endinterface

// File: rtl/adder_slice.sv
// Combinational W-bit adder slice; port names match the csa/cra slices so they can be swapped in.
module adder_slice #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
endmodule

// File: rtl/adder_slice_sequencer.sv
// N-bit a+b+cin computed W bits per cycle through one adder slice, carry held in a register.
// Optional group propagate/generate outputs are enabled by defining ADDSEQ_PG_EN.
module adder_slice_sequencer
    import adder_seq_pkg::*;
#(
    parameter int unsigned N = 256,
    parameter int unsigned W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    adder_slice_sequencer_if.slave  bus
);
    localparam int unsigned NS    = ns_f(N, W);
    localparam int unsigned IDX_W = idx_w_f(NS);

    generate
        if ((N % W) != 0 || NS < 2) begin : g_bad_cfg
            $error("adder_slice_sequencer: N must be a multiple of W with N/W >= 2");
        end
    endgenerate

    state_e           r_state;
    logic [N-1:0]     r_a_sh;
    logic [N-1:0]     r_b_sh;
    logic [N-W-1:0]   r_s_sh;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [N-1:0]     r_s;
    logic             r_cout;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [W-1:0]     w_sum;
    logic             w_c;
    logic [N-1:0]     w_s_next;
    logic             w_last;

    adder_slice #(.W(W)) u_slice (
        .a    (r_a_sh[W-1:0]),
        .b    (r_b_sh[W-1:0]),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_c)
    );

    // Completed slices accumulate at the top and move down one slot per cycle.
    assign w_s_next = {w_sum, r_s_sh};
    assign w_last   = (r_idx == IDX_W'(NS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_s_sh      <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sh     <= bus.a;
                        r_b_sh     <= bus.b;
                        r_carry    <= bus.cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_a_sh  <= {{W{1'b0}}, r_a_sh[N-1:W]};
                    r_b_sh  <= {{W{1'b0}}, r_b_sh[N-1:W]};
                    r_s_sh  <= w_s_next[N-1:W];
                    r_carry <= w_c;
                    if (w_last) begin
                        r_s         <= w_s_next;
                        r_cout      <= w_c;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

`ifdef ADDSEQ_PG_EN
    logic r_prop_acc;
    logic r_prop;
    logic r_gen;
    logic w_prop_k;

    assign w_prop_k = &(r_a_sh[W-1:0] ^ r_b_sh[W-1:0]);

    // Group P/G: propagate only if every slice propagates; generate is the carry not explained by cin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prop_acc <= 1'b0;
            r_prop     <= 1'b0;
            r_gen      <= 1'b0;
        end else if (r_state == IDLE && bus.in_valid) begin
            r_prop_acc <= 1'b1;
        end else if (r_state == RUN) begin
            r_prop_acc <= r_prop_acc & w_prop_k;
            if (w_last) begin
                r_prop <= r_prop_acc & w_prop_k;
                r_gen  <= w_c & ~(r_prop_acc & w_prop_k);
            end
        end
    end

    assign bus.prop = r_prop;
    assign bus.gen  = r_gen;
`else
    assign bus.prop = 1'b0;
    assign bus.gen  = 1'b0;
`endif

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.s         = r_s;
    assign bus.cout      = r_cout;
endmodule

// File: tb/tb_adder_slice_sequencer.sv
// Directed-vector bench for adder_slice_sequencer (N=256, W=32), plus backpressure and mid-run reset sequences.
module tb_adder_slice_sequencer;
    localparam int unsigned N  = 256;
    localparam int unsigned W  = 32;
    localparam int          NS = 8;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] s;
        logic         cout;
        logic         prop;
        logic         gen;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    adder_slice_sequencer_if #(.N(N)) bus ();

    adder_slice_sequencer #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 32) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    vec_t         vecs [8];
    logic [N-1:0] ones;
    logic [N-1:0] top;
    logic [N-1:0] pat_a;
    logic [N-1:0] pat_b;
    logic         ep;
    logic         eg;
    int           lat;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ones  = '1;
        top   = N'(1) << (N - 1);
        pat_a = {8{32'h89AB_CDEF}};
        pat_b = {8{32'h7654_3210}};

        //           a                b            cin   s                      cout  prop  gen
        vecs[0] = '{ '0,              '0,          1'b1, N'(1),                 1'b0, 1'b0, 1'b0 };
        vecs[1] = '{ ones,            '0,          1'b1, '0,                    1'b1, 1'b1, 1'b0 };
        vecs[2] = '{ top,             top,         1'b0, '0,                    1'b1, 1'b0, 1'b1 };
        vecs[3] = '{ N'(64'hFFFF_FFFF), N'(1),     1'b0, N'(64'h1_0000_0000),   1'b0, 1'b0, 1'b0 };
        vecs[4] = '{ ones,            ones,        1'b1, ones,                  1'b1, 1'b0, 1'b1 };
        vecs[5] = '{ pat_a,           pat_b,       1'b1, '0,                    1'b1, 1'b1, 1'b0 };
        vecs[6] = '{ pat_a,           pat_b,       1'b0, ones,                  1'b0, 1'b1, 1'b0 };
        vecs[7] = '{ ones,            '0,          1'b0, ones,                  1'b0, 1'b1, 1'b0 };

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_in_ready",  N'(bus.in_ready),  N'(1));
        chk("rst_out_valid", N'(bus.out_valid), N'(0));
        chk("rst_busy",      N'(bus.busy),      N'(0));
        chk("rst_s",         bus.s,             '0);
        chk("rst_cout",      N'(bus.cout),      N'(0));
        chk("rst_prop",      N'(bus.prop),      N'(0));
        chk("rst_gen",       N'(bus.gen),       N'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
`ifdef ADDSEQ_PG_EN
            ep = vecs[i].prop;
            eg = vecs[i].gen;
`else
            ep = 1'b0;
            eg = 1'b0;
`endif
            bus.out_ready = 1'b1;
            chk($sformatf("v%0d_in_ready_idle", i), N'(bus.in_ready), N'(1));
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
            chk($sformatf("v%0d_busy_run", i),     N'(bus.busy),     N'(1));
            chk($sformatf("v%0d_in_ready_run", i), N'(bus.in_ready), N'(0));
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), N'(lat),          N'(NS));
            chk($sformatf("v%0d_s", i),       bus.s,            vecs[i].s);
            chk($sformatf("v%0d_cout", i),    N'(bus.cout),     N'(vecs[i].cout));
            chk($sformatf("v%0d_prop", i),    N'(bus.prop),     N'(ep));
            chk($sformatf("v%0d_gen", i),     N'(bus.gen),      N'(eg));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid_drop", i), N'(bus.out_valid), N'(0));
            chk($sformatf("v%0d_in_ready_back", i),  N'(bus.in_ready),  N'(1));
            chk($sformatf("v%0d_s_held", i),         bus.s,             vecs[i].s);
        end

        // Backpressure in DONE with an ignored request pulse.
        bus.out_ready = 1'b0;
        start_op(N'(64'hFFFF_FFFF), N'(1), 1'b0);
        wait_done(lat);
        chk("bp_latency", N'(lat), N'(NS));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.in_valid = (c == 2);
            bus.a        = ones;
            bus.b        = ones;
            bus.cin      = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_out_valid", c), N'(bus.out_valid), N'(1));
            chk($sformatf("bp%0d_s", c),         bus.s,             N'(64'h1_0000_0000));
            chk($sformatf("bp%0d_cout", c),      N'(bus.cout),      N'(0));
            chk($sformatf("bp%0d_in_ready", c),  N'(bus.in_ready),  N'(0));
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", N'(bus.out_valid), N'(0));
        chk("bp_release_in_ready",  N'(bus.in_ready),  N'(1));
        chk("bp_release_s_held",    bus.s,             N'(64'h1_0000_0000));
        @(posedge clk);
        #1;
        chk("bp_pulse_not_queued", N'(bus.busy), N'(0));

        // Asynchronous reset after slice 3 of a running operation.
        start_op(ones, ones, 1'b1);
        repeat (4) @(posedge clk);
        #3;
        chk("mid_busy_before_rst", N'(bus.busy), N'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", N'(bus.out_valid), N'(0));
        chk("mid_rst_s",         bus.s,             '0);
        chk("mid_rst_busy",      N'(bus.busy),      N'(0));
        chk("mid_rst_in_ready",  N'(bus.in_ready),  N'(1));
        chk("mid_rst_cout",      N'(bus.cout),      N'(0));
        @(negedge clk);
        rst_n = 1'b1;
        start_op(N'(5), N'(7), 1'b0);
        wait_done(lat);
        chk("post_rst_latency", N'(lat),      N'(NS));
        chk("post_rst_s",       bus.s,        N'(12));
        chk("post_rst_cout",    N'(bus.cout), N'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
